// File: rtl/fir_seq_ctrl.sv
// Run sequencer for the 5-tap FIR: flushes filter history, streams N_SAMPLES reads into the
// filter and writes the aligned results out, then pulses done with the run length.
module fir_seq_ctrl #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned N_SAMPLES = 1024,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned FIR_LAT   = 3,
  parameter int unsigned FLUSH     = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [7:0]        i_rd_data,
  output logic [7:0]        o_fir_din,
  input  logic [11:0]       i_fir_dout,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [11:0]       o_wr_data,
  output logic [31:0]       o_cycle_count
);

  localparam int unsigned       PIPE_LEN   = RD_LAT + FIR_LAT;
  localparam int unsigned       PCNT_W     = (FLUSH > 1) ? $clog2(FLUSH) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(N_SAMPLES - 1);
  localparam logic [PCNT_W-1:0] LAST_PRIME = PCNT_W'(FLUSH - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PRIME = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]          r_state;
  logic [2:0]          w_state_d;
  logic [PCNT_W-1:0]   r_prime_cnt;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [PIPE_LEN-1:0] r_vld;
  logic [31:0]         r_cycle_count;
  logic                w_rd_en;
  logic                w_din_vld;
  logic                w_wr_en;
  logic                w_last_wr;

  // r_vld[i] is rd_en delayed by i+1 cycles; RD_LAT and FIR_LAT are both assumed >= 1.
  assign w_rd_en   = (r_state == ST_RUN);
  assign w_din_vld = r_vld[RD_LAT-1];
  assign w_wr_en   = r_vld[PIPE_LEN-1];
  assign w_last_wr = w_wr_en && (r_wr_addr == LAST_ADDR);

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      ST_IDLE:  if (i_start) w_state_d = ST_PRIME;
      ST_PRIME: if (r_prime_cnt == LAST_PRIME) w_state_d = ST_RUN;
      ST_RUN:   if (r_rd_addr == LAST_ADDR) w_state_d = ST_DRAIN;
      ST_DRAIN: if (w_last_wr) w_state_d = ST_DONE;
      ST_DONE:  w_state_d = ST_IDLE;
      default:  w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_prime_cnt   <= '0;
      r_rd_addr     <= '0;
      r_wr_addr     <= '0;
      r_vld         <= '0;
      r_cycle_count <= '0;
    end else begin
      r_state <= w_state_d;
      r_vld   <= (r_vld << 1) | PIPE_LEN'(w_rd_en);
      // Addresses saturate at the last index so a full 2^ADDR_W run never wraps.
      if (w_wr_en && (r_wr_addr != LAST_ADDR)) r_wr_addr <= r_wr_addr + 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_prime_cnt   <= '0;
            r_rd_addr     <= '0;
            r_wr_addr     <= '0;
            r_cycle_count <= '0;
          end
        end
        ST_PRIME: begin
          r_prime_cnt   <= (r_prime_cnt == LAST_PRIME) ? '0 : r_prime_cnt + 1'b1;
          r_cycle_count <= r_cycle_count + 32'd1;
        end
        ST_RUN: begin
          if (r_rd_addr != LAST_ADDR) r_rd_addr <= r_rd_addr + 1'b1;
          r_cycle_count <= r_cycle_count + 32'd1;
        end
        ST_DRAIN: r_cycle_count <= r_cycle_count + 32'd1;
        default: ;
      endcase
    end
  end

  assign o_busy        = (r_state != ST_IDLE);
  assign o_done        = (r_state == ST_DONE);
  assign o_rd_en       = w_rd_en;
  assign o_rd_addr     = r_rd_addr;
  assign o_fir_din     = w_din_vld ? i_rd_data : 8'd0;
  assign o_wr_en       = w_wr_en;
  assign o_wr_addr     = r_wr_addr;
  assign o_wr_data     = i_fir_dout;
  assign o_cycle_count = r_cycle_count;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Bench for fir_seq_ctrl: three sequencers (8 samples, 16 samples, 3-bit addresses) each wired
// to behavioural input BRAM, 1-2-3-2-1 FIR (latency 3) and output BRAM models.
module tb_fir_seq_ctrl;

  typedef logic [15:0][7:0]  xvec_t;
  typedef logic [15:0][11:0] yvec_t;
  typedef struct packed {
    logic  pre;
    xvec_t x;
    yvec_t y;
  } vec_t;

  localparam int DoneOff = 10;  // FLUSH + RD_LAT + FIR_LAT + 1 with default parameters

  logic        clk = 1'b0;
  int unsigned tick = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [7:0]  in_mem [3][16];

  always #5 clk = ~clk;
  always @(posedge clk) tick <= tick + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [11:0] fir_sum(input logic [4:0][7:0] h);
    return 12'(h[0]) + 12'(h[1]) * 12'd2 + 12'(h[2]) * 12'd3 + 12'(h[3]) * 12'd2 + 12'(h[4]);
  endfunction

  // ---------------- instance A: ADDR_W=10, N_SAMPLES=8 ----------------
  logic a_start = 0, a_rst = 1, a_pre = 0, a_clr = 0;
  logic a_busy, a_done, a_rd_en, a_wr_en;
  logic [9:0] a_rd_addr, a_wr_addr;
  logic [7:0] a_rd_data, a_fir_din;
  logic [11:0] a_fir_dout, a_wr_data, a_p1;
  logic [31:0] a_cyc;
  logic [4:0][7:0] a_h;
  logic [11:0] a_out [16];
  logic [3:0] a_rdlog [16];
  int a_wr_n = 0, a_rd_n = 0, a_done_n = 0;

  fir_seq_ctrl #(.ADDR_W(10), .N_SAMPLES(8)) u_dut_a (
    .i_clk(clk), .i_rst(a_rst), .i_start(a_start), .o_busy(a_busy), .o_done(a_done),
    .o_rd_en(a_rd_en), .o_rd_addr(a_rd_addr), .i_rd_data(a_rd_data), .o_fir_din(a_fir_din),
    .i_fir_dout(a_fir_dout), .o_wr_en(a_wr_en), .o_wr_addr(a_wr_addr), .o_wr_data(a_wr_data),
    .o_cycle_count(a_cyc)
  );

  always @(posedge clk) begin
    if (a_rd_en) a_rd_data <= in_mem[0][a_rd_addr[3:0]];
    a_h        <= a_pre ? {5{8'hFF}} : {a_h[3:0], a_fir_din};
    a_p1       <= fir_sum(a_h);
    a_fir_dout <= a_p1;
    if (a_clr) begin
      a_wr_n <= 0; a_rd_n <= 0; a_done_n <= 0;
      for (int k = 0; k < 16; k++) a_out[k] <= 12'hFFF;
    end else begin
      if (a_wr_en) begin a_out[a_wr_addr[3:0]] <= a_wr_data; a_wr_n <= a_wr_n + 1; end
      if (a_rd_en) begin a_rdlog[a_rd_n[3:0]] <= a_rd_addr[3:0]; a_rd_n <= a_rd_n + 1; end
      if (a_done) a_done_n <= a_done_n + 1;
    end
  end

  // ---------------- instance B: ADDR_W=10, N_SAMPLES=16 ----------------
  logic b_start = 0, b_rst = 1, b_pre = 0, b_clr = 0;
  logic b_busy, b_done, b_rd_en, b_wr_en;
  logic [9:0] b_rd_addr, b_wr_addr;
  logic [7:0] b_rd_data, b_fir_din;
  logic [11:0] b_fir_dout, b_wr_data, b_p1;
  logic [31:0] b_cyc;
  logic [4:0][7:0] b_h;
  logic [11:0] b_out [16];
  logic [3:0] b_rdlog [16];
  int b_wr_n = 0, b_rd_n = 0, b_done_n = 0;

  fir_seq_ctrl #(.ADDR_W(10), .N_SAMPLES(16)) u_dut_b (
    .i_clk(clk), .i_rst(b_rst), .i_start(b_start), .o_busy(b_busy), .o_done(b_done),
    .o_rd_en(b_rd_en), .o_rd_addr(b_rd_addr), .i_rd_data(b_rd_data), .o_fir_din(b_fir_din),
    .i_fir_dout(b_fir_dout), .o_wr_en(b_wr_en), .o_wr_addr(b_wr_addr), .o_wr_data(b_wr_data),
    .o_cycle_count(b_cyc)
  );

  always @(posedge clk) begin
    if (b_rd_en) b_rd_data <= in_mem[1][b_rd_addr[3:0]];
    b_h        <= b_pre ? {5{8'hFF}} : {b_h[3:0], b_fir_din};
    b_p1       <= fir_sum(b_h);
    b_fir_dout <= b_p1;
    if (b_clr) begin
      b_wr_n <= 0; b_rd_n <= 0; b_done_n <= 0;
      for (int k = 0; k < 16; k++) b_out[k] <= 12'hFFF;
    end else begin
      if (b_wr_en) begin b_out[b_wr_addr[3:0]] <= b_wr_data; b_wr_n <= b_wr_n + 1; end
      if (b_rd_en) begin b_rdlog[b_rd_n[3:0]] <= b_rd_addr[3:0]; b_rd_n <= b_rd_n + 1; end
      if (b_done) b_done_n <= b_done_n + 1;
    end
  end

  // ---------------- instance C: ADDR_W=3, N_SAMPLES=8 (full address space) ----------------
  logic c_start = 0, c_rst = 1, c_pre = 0, c_clr = 0;
  logic c_busy, c_done, c_rd_en, c_wr_en;
  logic [2:0] c_rd_addr, c_wr_addr;
  logic [7:0] c_rd_data, c_fir_din;
  logic [11:0] c_fir_dout, c_wr_data, c_p1;
  logic [31:0] c_cyc;
  logic [4:0][7:0] c_h;
  logic [11:0] c_out [16];
  logic [3:0] c_rdlog [16];
  int c_wr_n = 0, c_rd_n = 0, c_done_n = 0;

  fir_seq_ctrl #(.ADDR_W(3), .N_SAMPLES(8)) u_dut_c (
    .i_clk(clk), .i_rst(c_rst), .i_start(c_start), .o_busy(c_busy), .o_done(c_done),
    .o_rd_en(c_rd_en), .o_rd_addr(c_rd_addr), .i_rd_data(c_rd_data), .o_fir_din(c_fir_din),
    .i_fir_dout(c_fir_dout), .o_wr_en(c_wr_en), .o_wr_addr(c_wr_addr), .o_wr_data(c_wr_data),
    .o_cycle_count(c_cyc)
  );

  always @(posedge clk) begin
    if (c_rd_en) c_rd_data <= in_mem[2][{1'b0, c_rd_addr}];
    c_h        <= c_pre ? {5{8'hFF}} : {c_h[3:0], c_fir_din};
    c_p1       <= fir_sum(c_h);
    c_fir_dout <= c_p1;
    if (c_clr) begin
      c_wr_n <= 0; c_rd_n <= 0; c_done_n <= 0;
      for (int k = 0; k < 16; k++) c_out[k] <= 12'hFFF;
    end else begin
      if (c_wr_en) begin c_out[{1'b0, c_wr_addr}] <= c_wr_data; c_wr_n <= c_wr_n + 1; end
      if (c_rd_en) begin c_rdlog[c_rd_n[3:0]] <= {1'b0, c_rd_addr}; c_rd_n <= c_rd_n + 1; end
      if (c_done) c_done_n <= c_done_n + 1;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic xvec_t xv8(input int a0, a1, a2, a3, a4, a5, a6, a7);
    xvec_t v = '0;
    v[0] = 8'(a0); v[1] = 8'(a1); v[2] = 8'(a2); v[3] = 8'(a3);
    v[4] = 8'(a4); v[5] = 8'(a5); v[6] = 8'(a6); v[7] = 8'(a7);
    return v;
  endfunction

  function automatic yvec_t yv8(input int a0, a1, a2, a3, a4, a5, a6, a7);
    yvec_t v = '0;
    v[0] = 12'(a0); v[1] = 12'(a1); v[2] = 12'(a2); v[3] = 12'(a3);
    v[4] = 12'(a4); v[5] = 12'(a5); v[6] = 12'(a6); v[7] = 12'(a7);
    return v;
  endfunction

  function automatic logic get_busy(input int id);
    case (id) 0: return a_busy; 1: return b_busy; default: return c_busy; endcase
  endfunction
  function automatic logic get_done(input int id);
    case (id) 0: return a_done; 1: return b_done; default: return c_done; endcase
  endfunction
  function automatic logic [31:0] get_cyc(input int id);
    case (id) 0: return a_cyc; 1: return b_cyc; default: return c_cyc; endcase
  endfunction
  function automatic logic [11:0] get_out(input int id, input int k);
    case (id) 0: return a_out[k]; 1: return b_out[k]; default: return c_out[k]; endcase
  endfunction
  function automatic logic [3:0] get_rdlog(input int id, input int k);
    case (id) 0: return a_rdlog[k]; 1: return b_rdlog[k]; default: return c_rdlog[k]; endcase
  endfunction
  function automatic int get_wr_n(input int id);
    case (id) 0: return a_wr_n; 1: return b_wr_n; default: return c_wr_n; endcase
  endfunction
  function automatic int get_rd_n(input int id);
    case (id) 0: return a_rd_n; 1: return b_rd_n; default: return c_rd_n; endcase
  endfunction
  function automatic int get_done_n(input int id);
    case (id) 0: return a_done_n; 1: return b_done_n; default: return c_done_n; endcase
  endfunction

  task automatic set_start(input int id, input logic v, input logic pre);
    case (id)
      0: begin a_start = v; a_pre = pre; end
      1: begin b_start = v; b_pre = pre; end
      default: begin c_start = v; c_pre = pre; end
    endcase
  endtask

  task automatic clear_log(input int id);
    @(negedge clk);
    case (id) 0: a_clr = 1'b1; 1: b_clr = 1'b1; default: c_clr = 1'b1; endcase
    @(negedge clk);
    a_clr = 1'b0; b_clr = 1'b0; c_clr = 1'b0;
  endtask

  task automatic load(input int id, input xvec_t x);
    for (int k = 0; k < 16; k++) in_mem[id][k] = x[k];
  endtask

  // Start is held through edge 0; returns at the negedge of cycle 1, t0 = tick of cycle 0.
  task automatic start_run(input int id, input logic pre, output int unsigned t0);
    @(negedge clk);
    set_start(id, 1'b1, pre);
    t0 = tick;
    @(negedge clk);
    set_start(id, 1'b0, 1'b0);
  endtask

  task automatic wait_done(input int id, input string tag, input int unsigned t0,
                           input int exp_cycle);
    int n = 0;
    while (get_done(id) !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " done cycle"}, 64'(tick - t0), 64'(exp_cycle));
    chk({tag, " busy in done"}, 64'(get_busy(id)), 64'd1);
  endtask

  task automatic check_results(input int id, input string tag, input int n, input yvec_t y,
                               input int cyc, input int runs);
    for (int k = 0; k < n; k++) chk($sformatf("%s out[%0d]", tag, k), get_out(id, k), y[k]);
    for (int k = 0; k < n; k++)
      chk($sformatf("%s rd_addr #%0d", tag, k), get_rdlog(id, (runs - 1) * n + k), 64'(k));
    chk({tag, " wr_en count"}, 64'(get_wr_n(id)), 64'(n * runs));
    chk({tag, " rd_en count"}, 64'(get_rd_n(id)), 64'(n * runs));
    chk({tag, " done pulses"}, 64'(get_done_n(id)), 64'(runs));
    chk({tag, " cycle_count"}, get_cyc(id), 64'(cyc));
  endtask

  task automatic run_full(input int id, input string tag, input int n, input logic pre,
                          input yvec_t y, input int cyc, input logic poke);
    int unsigned t0;
    clear_log(id);
    start_run(id, pre, t0);
    wait_done(id, tag, t0, n + DoneOff);
    if (poke) set_start(id, 1'b1, 1'b0);
    @(negedge clk);
    set_start(id, 1'b0, 1'b0);
    chk({tag, " busy after done"}, 64'(get_busy(id)), 64'd0);
    chk({tag, " done width"}, 64'(get_done(id)), 64'd0);
    if (poke) begin
      repeat (3) @(negedge clk);
      chk({tag, " start at done dropped"}, 64'(get_busy(id)), 64'd0);
    end
    check_results(id, tag, n, y, cyc, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    vec_t vecs [4];
    yvec_t ysat;
    int unsigned t0;

    vecs[0] = '{pre: 1'b0, x: xv8(1, 2, 3, 4, 5, 6, 7, 8),
                y: yv8(1, 4, 10, 18, 27, 36, 45, 54)};
    vecs[1] = '{pre: 1'b1, x: xv8(0, 0, 0, 0, 0, 0, 0, 0),
                y: yv8(0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[2] = '{pre: 1'b0, x: xv8(8, 7, 6, 5, 4, 3, 2, 1),
                y: yv8(8, 23, 44, 54, 54, 45, 36, 27)};
    vecs[3] = '{pre: 1'b1, x: xv8(0, 0, 100, 0, 0, 0, 0, 0),
                y: yv8(0, 0, 100, 200, 300, 200, 100, 0)};
    for (int k = 0; k < 16; k++) ysat[k] = (k == 0) ? 12'd255 : (k == 1) ? 12'd765 :
                                           (k == 2) ? 12'd1530 : (k == 3) ? 12'd2040 : 12'd2295;

    repeat (8) @(negedge clk);
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    chk("reset busy", 64'(a_busy), 64'd0);
    chk("reset done", 64'(a_done), 64'd0);
    chk("reset rd_en", 64'(a_rd_en), 64'd0);
    chk("reset rd_addr", 64'(a_rd_addr), 64'd0);
    chk("reset fir_din", 64'(a_fir_din), 64'd0);
    chk("reset wr_en", 64'(a_wr_en), 64'd0);
    chk("reset wr_addr", 64'(a_wr_addr), 64'd0);
    chk("reset cycle_count", a_cyc, 64'd0);
    chk("reset wr_data", 64'(a_wr_data), 64'(a_fir_dout));

    // Table-driven runs; the last one also pokes start during the done cycle.
    for (int i = 0; i < 4; i++) begin
      load(0, vecs[i].x);
      run_full(0, $sformatf("vec%0d", i), 8, vecs[i].pre, vecs[i].y, 17, i == 3);
    end

    // Extra start in the middle of RUN must be dropped.
    load(0, vecs[0].x);
    clear_log(0);
    start_run(0, 1'b0, t0);
    repeat (7) @(negedge clk);
    set_start(0, 1'b1, 1'b0);
    @(negedge clk);
    set_start(0, 1'b0, 1'b0);
    wait_done(0, "midstart", t0, 8 + DoneOff);
    @(negedge clk);
    check_results(0, "midstart", 8, vecs[0].y, 17, 1);

    // Reset in DRAIN (cycle 15): writes land in cycles 10..15, nothing afterwards.
    clear_log(0);
    start_run(0, 1'b0, t0);
    while (tick - t0 < 15) @(negedge clk);
    a_rst = 1'b1;
    @(negedge clk);
    a_rst = 1'b0;
    chk("rst busy", 64'(a_busy), 64'd0);
    chk("rst wr_en", 64'(a_wr_en), 64'd0);
    chk("rst cycle_count", a_cyc, 64'd0);
    chk("rst writes before", 64'(a_wr_n), 64'd6);
    repeat (10) @(negedge clk);
    chk("rst writes after", 64'(a_wr_n), 64'd6);
    chk("rst no done", 64'(a_done_n), 64'd0);
    chk("rst still idle", 64'(a_busy), 64'd0);
    run_full(0, "after_rst", 8, 1'b0, vecs[0].y, 17, 1'b0);

    // Full-scale input, 16 samples: saturating sums must not overflow 12 bits.
    load(1, {16{8'd255}});
    run_full(1, "sat", 16, 1'b0, ysat, 25, 1'b0);

    // 3-bit addresses, back-to-back runs with the second start in the first IDLE cycle.
    load(2, vecs[0].x);
    clear_log(2);
    start_run(2, 1'b0, t0);
    wait_done(2, "b2b1", t0, 8 + DoneOff);
    @(negedge clk);
    chk("b2b1 busy after done", 64'(c_busy), 64'd0);
    check_results(2, "b2b1", 8, vecs[0].y, 17, 1);
    chk("b2b1 rd_addr end", 64'(c_rd_addr), 64'd7);
    chk("b2b1 wr_addr end", 64'(c_wr_addr), 64'd7);
    load(2, vecs[2].x);
    set_start(2, 1'b1, 1'b0);
    t0 = tick;
    @(negedge clk);
    set_start(2, 1'b0, 1'b0);
    chk("b2b2 accepted", 64'(c_busy), 64'd1);
    wait_done(2, "b2b2", t0, 8 + DoneOff);
    @(negedge clk);
    check_results(2, "b2b2", 8, vecs[2].y, 17, 2);
    chk("b2b2 rd_addr end", 64'(c_rd_addr), 64'd7);
    chk("b2b2 wr_addr end", 64'(c_wr_addr), 64'd7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fir_seq_ctrl.md
# fir_seq_ctrl

Sequencer for the 5-tap FIR datapath (taps 1,2,3,2,1; 8-bit in, 12-bit out, 3-cycle input-to-output latency). On a start pulse it flushes the filter's history, streams N samples from the input BRAM into the filter, and writes the N aligned results to the output BRAM. It then reports completion and the cycle count of the run. It sits between the top-level run control and the FIR/BRAM pair, and is used unchanged for the pipelined and non-pipelined filter variants by setting FIR_LAT.

## Interface
Parameters:
- ADDR_W, 10 — address width of both BRAMs
- N_SAMPLES, 1024 — samples per run; legal range 1..2^ADDR_W
- RD_LAT, 1 — input BRAM read latency in cycles, from rd_en to rd_data valid
- FIR_LAT, 3 — FIR latency in cycles, from fir_din to the matching fir_dout
- FLUSH, 5 — number of zero samples fed before a run; must be ≥ tap count

Ports:
- clk  in  1  — single clock; all logic on the rising edge
- rst  in  1  — synchronous, active-high reset
- start  in  1  — one-cycle run request; ignored while busy
- busy  out  1  — high in every state except IDLE
- done  out  1  — one-cycle pulse at the end of a run
- rd_en  out  1  — input BRAM read enable
- rd_addr  out  ADDR_W  — input BRAM read address
- rd_data  in  8  — input BRAM read data
- fir_din  out  8  — sample driven to the FIR
- fir_dout  in  12  — FIR output
- wr_en  out  1  — output BRAM write enable
- wr_addr  out  ADDR_W  — output BRAM write address
- wr_data  out  12  — output BRAM write data; equals fir_dout
- cycle_count  out  32  — length of the last (or current) run in cycles

## Operation
- State machine: IDLE → PRIME → RUN → DRAIN → DONE → IDLE.
- IDLE: all strobes low. When start=1, clear the counters, set cycle_count=0, and go to PRIME.
- PRIME: stay for exactly FLUSH cycles. fir_din=0 throughout. rd_en=0.
- RUN: stay for exactly N_SAMPLES cycles. rd_en=1 every cycle. rd_addr=0,1,…,N_SAMPLES-1, one per cycle.
- DRAIN: stay until the last wr_en has been issued. Then go to DONE.
- DONE: done=1 for one cycle. Then go to IDLE.
- Valid pipeline: a shift register of length RD_LAT+FIR_LAT is fed by rd_en and cleared on rst.
  - fir_din = rd_data when the rd_en-delayed-by-RD_LAT tap is 1; otherwise fir_din=0.
  - wr_en = the rd_en-delayed-by-(RD_LAT+FIR_LAT) tap.
- wr_addr starts at 0 at each run and increments after each write. Result k is written to address k, for k=0..N_SAMPLES-1.
- Arithmetic is pass-through only; no width change is made to data. The maximum filter output is 255·9 = 2295, which fits in 12 bits.
- cycle_count increments in every PRIME, RUN and DRAIN cycle. It holds its value in DONE and IDLE, and is readable after done.
- A start received while busy=1 is dropped; it is not queued.
- rst in any state: return to IDLE on the next edge and clear the valid pipeline. No wr_en is issued after reset, including for reads already in flight. Outputs go to their reset values.

## Timing
- Reset values: busy=0, done=0, rd_en=0, rd_addr=0, fir_din=0, wr_en=0, wr_addr=0, wr_data follows fir_dout, cycle_count=0.
- Cycle numbering: start is sampled at edge 0. PRIME occupies cycles 1..FLUSH.
- RUN occupies cycles FLUSH+1 .. FLUSH+N_SAMPLES.
- A read issued in cycle c produces a write in cycle c+RD_LAT+FIR_LAT.
- The last write occurs in cycle FLUSH+N_SAMPLES+RD_LAT+FIR_LAT.
- done occurs in the following cycle. busy falls one cycle after done.
- With default parameters: cycle_count = N_SAMPLES+9.
- With N_SAMPLES=2^ADDR_W: rd_addr and wr_addr end at all-ones. They must not wrap before the run ends.
- A start arriving in the same cycle as done is ignored. A start in the first IDLE cycle after DONE is accepted.

## Test plan
Default parameters throughout unless stated.
- N_SAMPLES=8, input BRAM holds x=1..8, start pulse → output BRAM addresses 0..4 hold 1,4,10,18,27, and addresses 5..7 hold 36,45,54. Exactly 8 wr_en cycles occur; done pulses once; cycle_count=17.
- Preload the FIR history with 0xFF, then run N_SAMPLES=8 with all samples 0 → all 8 outputs are 0, confirming PRIME flushes stale state.
- All samples 255, N_SAMPLES=16 → outputs are 255,765,1530,2040, then 2295 for the remaining 12 writes. No 12-bit overflow occurs.
- Pulse start again in the middle of RUN → the extra start is ignored: addresses and counts are identical to a single run, and done pulses once.
- Assert rst for one cycle during DRAIN → busy=0 and wr_en=0 from the next cycle onward. No further writes occur. A subsequent start produces a correct full run.
- ADDR_W=3, N_SAMPLES=8 → rd_addr and wr_addr reach 7 without wrapping mid-run. Back-to-back starts, each issued one cycle after done, both complete with correct results.
